// File: rtl/round_robin_arbiter.sv
// Purpose: 8-way round-robin arbiter with a bounded hold time per grant.
// Latency: a grant is visible one cycle after the request is sampled in IDLE; every grant is followed by one IDLE cycle.
// Backpressure: the owner keeps the grant while its request stays high, for at most MAX_HOLD cycles (force-release pulses timeout).
//
// Ports:
//   clk      - single clock, all state updates on the rising edge
//   rst      - synchronous active-high reset
//   req      - request lines, req[k] high = requester k wants the resource
//   gnt      - registered one-hot grant, all-zero when idle
//   gnt_idx  - registered binary index of the current/last granted requester
//   busy     - registered, high while a grant is held
//   timeout  - registered one-cycle pulse when a grant is force-released
module round_robin_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Counter value seen during the last permitted grant cycle.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] idx_q, idx_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] ptr_q, ptr_d;

    logic       pick_vld;
    logic [2:0] pick_idx;
    logic [2:0] cand;

    // Search ptr+1, ptr+2, ... (wrapping modulo 8). Iterating from the far
    // end lets the nearest requesting candidate overwrite the others.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        cand     = 3'd0;
        for (int i = 8; i >= 1; i--) begin
            cand = ptr_q + 3'(i);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    idx_d   = pick_idx;
                    gnt_d   = 8'd1 << pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = 8'd0;
                end
            end
            GRANT: begin
                // A voluntary release wins over a coinciding hold limit, so
                // timeout only pulses when the owner still wanted the grant.
                if (!req[idx_q] || (cnt_q == HOLD_LAST)) begin
                    state_d   = IDLE;
                    gnt_d     = 8'h00;
                    busy_d    = 1'b0;
                    ptr_d     = idx_q;
                    timeout_d = req[idx_q];
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 8'h00;
            idx_q     <= 3'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= 8'd0;
            ptr_q     <= 3'd7;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
